// File: rtl/aes_sbox_if.sv
// Bundles the request/response signals between the AES round controller and
// the SubBytes engine. master = round controller, slave = aes_sbox_matrix.
interface aes_sbox_if #(
    parameter int NO_ROWS = 4,
    parameter int NO_COLS = 4
);
    logic                                  sbox_en;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  sbox_ip_char_matrix;
    logic [NO_ROWS-1:0]                    sbox_ip_char_row_mask;
    logic [NO_COLS-1:0]                    sbox_ip_char_col_mask;
    logic                                  sbox_inv_i;
    logic                                  sbox_op_char_matrix_valid;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  sbox_op_char_matrix;

    modport master (
        output sbox_en,
        output sbox_ip_char_matrix,
        output sbox_ip_char_row_mask,
        output sbox_ip_char_col_mask,
        output sbox_inv_i,
        input  sbox_op_char_matrix_valid,
        input  sbox_op_char_matrix
    );

    modport slave (
        input  sbox_en,
        input  sbox_ip_char_matrix,
        input  sbox_ip_char_row_mask,
        input  sbox_ip_char_col_mask,
        input  sbox_inv_i,
        output sbox_op_char_matrix_valid,
        output sbox_op_char_matrix
    );
endinterface

// File: rtl/aes_sbox_matrix.sv
// AES SubBytes engine: masked, fully parallel S-box over the state matrix, registered with valid.
// Optional macro SBOX_INV_EN compiles in the inverse S-box, selected by sbox_inv_i.
module aes_sbox_matrix #(
    parameter int NO_ROWS = 4,
    parameter int NO_COLS = 4
) (
    input  logic        aes_clk,
    input  logic        resetn,
    aes_sbox_if.slave   bus
);

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SBOX_INV_EN
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`else
    // Inverse select has no function without the inverse table.
    logic unused_inv;
    assign unused_inv = bus.sbox_inv_i;
`endif

    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] matrix_d, matrix_q;
    logic                                 valid_d, valid_q;

    always_comb begin
        matrix_d = bus.sbox_ip_char_matrix;
        valid_d  = bus.sbox_en;
        for (int r = 0; r < NO_ROWS; r++) begin
            for (int c = 0; c < NO_COLS; c++) begin
                if (bus.sbox_ip_char_row_mask[r] && bus.sbox_ip_char_col_mask[c]) begin
`ifdef SBOX_INV_EN
                    matrix_d[r][c] = bus.sbox_inv_i ? SBOX_INV[bus.sbox_ip_char_matrix[r][c]]
                                                    : SBOX_FWD[bus.sbox_ip_char_matrix[r][c]];
`else
                    matrix_d[r][c] = SBOX_FWD[bus.sbox_ip_char_matrix[r][c]];
`endif
                end
            end
        end
    end

    // Data only loads on a request so the last result stays readable after valid drops.
    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            matrix_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (bus.sbox_en) begin
                matrix_q <= matrix_d;
            end
        end
    end

    assign bus.sbox_op_char_matrix_valid = valid_q;
    assign bus.sbox_op_char_matrix       = matrix_q;

endmodule

// File: tb/tb_aes_sbox_matrix.sv
// Directed bench for aes_sbox_matrix; the S-box reference is rebuilt from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes_sbox_matrix;

    typedef logic [3:0][3:0][7:0] mat_t;

    logic aes_clk = 1'b0;
    logic resetn  = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] rev_tab [256];

    aes_sbox_if #(.NO_ROWS(4), .NO_COLS(4)) bus ();

    aes_sbox_matrix #(.NO_ROWS(4), .NO_COLS(4)) dut (
        .aes_clk (aes_clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 aes_clk = ~aes_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aes_clk);
        #1;
    endtask

    function automatic mat_t fill(input logic [7:0] b);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = b;
        return m;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    function automatic mat_t model(input mat_t m);
        mat_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = fwd_tab[m[r][c]];
        return o;
    endfunction

    initial begin
        mat_t m, e, orig, fwd;
        int waited;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv, s;
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            fwd_tab[x] = s;
            rev_tab[s] = 8'(x);
        end

        bus.sbox_en = 1'b0;
        bus.sbox_ip_char_matrix = '0;
        bus.sbox_ip_char_row_mask = 4'hf;
        bus.sbox_ip_char_col_mask = 4'hf;
        bus.sbox_inv_i = 1'b0;

        #1;
        chk("reset_valid", 128'(bus.sbox_op_char_matrix_valid), 128'd0);
        chk("reset_data", bus.sbox_op_char_matrix, '0);
        cyc();
        resetn = 1'b1;
        cyc();
        chk("idle_valid", 128'(bus.sbox_op_char_matrix_valid), 128'd0);

        // Single-cycle pulse: row0 = FIPS-197 round example column
        m = fill(8'h00);
        m[0][0] = 8'h19; m[0][1] = 8'ha0; m[0][2] = 8'h9a; m[0][3] = 8'he9;
        e = fill(8'h63);
        e[0][0] = 8'hd4; e[0][1] = 8'he0; e[0][2] = 8'hb8; e[0][3] = 8'h1e;
        bus.sbox_ip_char_matrix = m;
        bus.sbox_en = 1'b1;
        cyc();
        chk("full_valid", 128'(bus.sbox_op_char_matrix_valid), 128'd1);
        chk("full_data", bus.sbox_op_char_matrix, e);
        bus.sbox_en = 1'b0;
        bus.sbox_ip_char_matrix = fill(8'hff);
        cyc();
        chk("full_valid_drop", 128'(bus.sbox_op_char_matrix_valid), 128'd0);
        chk("full_hold", bus.sbox_op_char_matrix, e);
        cyc();
        chk("idle_input_ignored", bus.sbox_op_char_matrix, e);

        // Partial masks
        bus.sbox_ip_char_matrix = fill(8'h53);
        bus.sbox_ip_char_row_mask = 4'b0101;
        bus.sbox_ip_char_col_mask = 4'b0011;
        e = fill(8'h53);
        e[0][0] = 8'hed; e[0][1] = 8'hed; e[2][0] = 8'hed; e[2][1] = 8'hed;
        bus.sbox_en = 1'b1;
        cyc();
        chk("mask_data", bus.sbox_op_char_matrix, e);

        // All masks clear: straight copy
        m = fill(8'h00);
        m[1][2] = 8'h53; m[3][0] = 8'hff; m[2][3] = 8'h01;
        bus.sbox_ip_char_matrix = m;
        bus.sbox_ip_char_row_mask = 4'h0;
        bus.sbox_ip_char_col_mask = 4'h0;
        cyc();
        chk("nomask_valid", 128'(bus.sbox_op_char_matrix_valid), 128'd1);
        chk("nomask_data", bus.sbox_op_char_matrix, m);
        bus.sbox_en = 1'b0;
        bus.sbox_ip_char_row_mask = 4'hf;
        bus.sbox_ip_char_col_mask = 4'hf;
        cyc();
        cyc();

        // Controller-style handshake
        bus.sbox_ip_char_matrix = fill(8'h01);
        bus.sbox_en = 1'b1;
        waited = 0;
        do begin
            cyc();
            waited++;
        end while (!bus.sbox_op_char_matrix_valid && waited < 8);
        chk("hs_latency", 128'(waited), 128'd1);
        chk("hs_data", bus.sbox_op_char_matrix, fill(8'h7c));
        bus.sbox_en = 1'b0;
        cyc();
        chk("hs_valid_drop", 128'(bus.sbox_op_char_matrix_valid), 128'd0);
        chk("hs_hold", bus.sbox_op_char_matrix, fill(8'h7c));

        // Held request streams with one-cycle lag
        bus.sbox_en = 1'b1;
        bus.sbox_ip_char_matrix = fill(8'h53);
        cyc();
        chk("stream0", bus.sbox_op_char_matrix, fill(8'hed));
        bus.sbox_ip_char_matrix = fill(8'hff);
        cyc();
        chk("stream1_valid", 128'(bus.sbox_op_char_matrix_valid), 128'd1);
        chk("stream1", bus.sbox_op_char_matrix, fill(8'h16));
        bus.sbox_ip_char_matrix = fill(8'h00);
        cyc();
        chk("stream2", bus.sbox_op_char_matrix, fill(8'h63));

        // All 256 values through [3][3]
        for (int v = 0; v < 256; v++) begin
            m = fill(8'h00);
            m[3][3] = 8'(v);
            bus.sbox_ip_char_matrix = m;
            cyc();
            chk($sformatf("sweep_%02h", v), 128'(bus.sbox_op_char_matrix[3][3]), 128'(fwd_tab[v]));
        end
        chk("sweep_ff_const", 128'(bus.sbox_op_char_matrix[3][3]), 128'h16);
        chk("sweep_other", 128'(bus.sbox_op_char_matrix[0][0]), 128'h63);

        // Asynchronous reset mid-run
        bus.sbox_ip_char_matrix = fill(8'h11);
        cyc();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 128'(bus.sbox_op_char_matrix_valid), 128'd0);
        chk("arst_data", bus.sbox_op_char_matrix, '0);
        cyc();
        chk("arst_hold_data", bus.sbox_op_char_matrix, '0);
        bus.sbox_en = 1'b0;
        resetn = 1'b1;
        cyc();
        cyc();
        chk("post_rst_valid", 128'(bus.sbox_op_char_matrix_valid), 128'd0);
        chk("post_rst_data", bus.sbox_op_char_matrix, '0);
        bus.sbox_en = 1'b1;
        cyc();
        chk("post_rst_first", bus.sbox_op_char_matrix, fill(fwd_tab[8'h11]));
        bus.sbox_en = 1'b0;
        cyc();

`ifdef SBOX_INV_EN
        bus.sbox_ip_char_matrix = fill(8'hed);
        bus.sbox_inv_i = 1'b1;
        bus.sbox_en = 1'b1;
        cyc();
        chk("inv_ed", bus.sbox_op_char_matrix, fill(8'h53));
        m = fill(8'h00);
        m[0][0] = 8'h63; m[1][1] = 8'h16; m[2][2] = 8'h7c;
        e = fill(8'h52);
        e[0][0] = 8'h00; e[1][1] = 8'hff; e[2][2] = 8'h01;
        bus.sbox_ip_char_matrix = m;
        cyc();
        chk("inv_points", bus.sbox_op_char_matrix, e);
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    orig[r][c] = 8'($urandom_range(0, 255));
            bus.sbox_inv_i = 1'b0;
            bus.sbox_ip_char_matrix = orig;
            cyc();
            fwd = bus.sbox_op_char_matrix;
            chk($sformatf("rt_fwd_%0d", t), fwd, model(orig));
            bus.sbox_inv_i = 1'b1;
            bus.sbox_ip_char_matrix = fwd;
            cyc();
            chk($sformatf("rt_inv_%0d", t), bus.sbox_op_char_matrix, orig);
        end
        chk("rev_tab_ed", 128'(rev_tab[8'hed]), 128'h53);
        bus.sbox_en = 1'b0;
        bus.sbox_inv_i = 1'b0;
        cyc();
`else
        bus.sbox_ip_char_matrix = fill(8'h00);
        bus.sbox_inv_i = 1'b1;
        bus.sbox_en = 1'b1;
        cyc();
        chk("inv_ignored", bus.sbox_op_char_matrix, fill(8'h63));
        bus.sbox_en = 1'b0;
        bus.sbox_inv_i = 1'b0;
        cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_sbox_matrix.md
Name: aes_sbox_matrix

Overview:
Byte-substitution (SubBytes) engine for the AES encryption core. It takes a NO_ROWS x NO_COLS state matrix of bytes and replaces each selected byte with its FIPS-197 forward S-box value. The result is registered and flagged with a valid strobe. The AES round controller drives sbox_en until it sees valid, then drops sbox_en and consumes the output matrix.

Parameters:
NO_ROWS, 4, number of state-matrix rows; legal range 1..4.
NO_COLS, 4, number of state-matrix columns; legal range 1..4.

Ports:
aes_clk  input  1  clock; all state updates on the rising edge.
resetn  input  1  asynchronous, active-low reset.
sbox_en  input  1  substitution request; sampled every rising edge.
sbox_ip_char_matrix  input  8 x [NO_ROWS][NO_COLS]  input state matrix, indexed [row][col].
sbox_ip_char_row_mask  input  NO_ROWS  bit r=1 enables substitution in row r.
sbox_ip_char_col_mask  input  NO_COLS  bit c=1 enables substitution in column c.
sbox_inv_i  input  1  inverse-table select; functional only with SBOX_INV_EN (see Optional Feature).
sbox_op_char_matrix_valid  output  1  output matrix holds a fresh result.
sbox_op_char_matrix  output  8 x [NO_ROWS][NO_COLS]  substituted matrix, indexed [row][col].

Behaviour:
- Reset (resetn low, asynchronous): valid=0; every output byte=8'h00. Reset asserted mid-operation aborts immediately. After release, no valid until a new sbox_en edge.
- Per byte [r][c]: out = SBOX(in) if row_mask[r] AND col_mask[c], else out = in (pass-through).
- SBOX is the fixed 256-entry FIPS-197 forward table (e.g. 00->63, 01->7C, 53->ED, FF->16). It is combinational ROM: a case statement or constant array.
- All 16 lookups run in parallel; there is no sequencing.
- Rising edge with sbox_en=1: output matrix <= substituted matrix from the inputs and masks present at that edge; valid <= 1.
- Rising edge with sbox_en=0: valid <= 0; output matrix holds its last value.
- Latency: exactly 1 clock from the sbox_en sample to valid=1 with the corresponding data.
- Held sbox_en: the block re-samples and re-substitutes every cycle. Valid stays 1 and data tracks the inputs with 1-cycle lag.
- Handshake with the controller: the controller holds sbox_en until it sees valid=1, then drops it. Valid falls one cycle after sbox_en falls. No back-pressure.
- Masks all zero with sbox_en=1: output = input copy, valid=1.
- Input changes while sbox_en=0 have no effect on the outputs.

Optional Feature:
Macro SBOX_INV_EN.
- Defined: the FIPS-197 inverse S-box table is compiled in. When sbox_inv_i=1 at the sampling edge, selected bytes use INV_SBOX (e.g. 63->00, ED->53, 16->FF). When sbox_inv_i=0, they use the forward table. Masks, latency and valid behave identically in both modes.
- Not defined: the inverse table is absent, sbox_inv_i is ignored, and the forward table is always used.

Test Plan:
- Reset: assert resetn=0 mid-run with sbox_en=1 -> valid=0 and all outputs 00 immediately; after release, outputs stay 00 until the first sbox_en edge.
- Full substitution: input row0 = {19,A0,9A,E9}, other bytes 00, both masks F, sbox_en pulsed 1 cycle -> next cycle valid=1, row0 = {D4,E0,B8,1E}, other bytes 63; the cycle after, valid=0 and data held.
- Masking: all input bytes 53, row_mask=4'b0101, col_mask=4'b0011 -> bytes [0][0],[0][1],[2][0],[2][1] = ED; all others 53.
- Handshake: hold sbox_en until valid, then drop (controller style) -> valid high exactly 1 cycle after sbox_en rises and low 1 cycle after it falls; data matches the last sampled input.
- Exhaustive table check: sweep all 256 values through byte [3][3] with full masks -> each output equals the FIPS-197 forward S-box (00->63, FF->16).
- SBOX_INV_EN build: sbox_inv_i=1, input all ED, full masks -> all outputs 53. Round-trip forward then inverse returns the original matrix for random data.
